// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lc3_mem_ctrl : MAR/MDR holder and wait-stated word RAM responder          |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
module lc3_mem_ctrl #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] marIn,
  input  logic        ldMAR,
  input  logic [15:0] mdrIn,
  input  logic        ldMDR,
  input  logic        memEn,
  input  logic        rw,
  output logic [15:0] marOut,
  output logic [15:0] mdrOut,
  output logic        ready,
  output logic        accErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        rw_q, rw_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        acc_err_q, acc_err_d;

  logic [15:0]          ram [DEPTH];
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 in_range;

  assign ram_addr = mar_q[ADDR_BITS-1:0];

  // A full 16-bit RAM has no upper address bits left to range-check.
  generate
    if (ADDR_BITS >= 16) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ~|mar_q[15:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mar_q     <= 16'h0000;
      mdr_q     <= 16'h0000;
      rw_q      <= 1'b0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      acc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      acc_err_q <= acc_err_d;
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= mdr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (memEn) state_d = S_BUSY;
      S_BUSY: if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    acc_err_d = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ldMAR) mar_d = marIn;
        if (ldMDR) mdr_d = mdrIn;
        // The request flops rw/cnt only; the access uses MAR/MDR as held after this edge.
        if (state_q == S_IDLE && memEn) begin
          rw_d  = rw;
          cnt_d = C_WAIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d   = 1'b1;
          acc_err_d = ~in_range;
          if (rw_q) begin
            ram_we = in_range;
          end else begin
            mdr_d = in_range ? ram[ram_addr] : 16'h0000;
          end
        end
      end
      default: begin
        cnt_d = 4'd0;
      end
    endcase
  end

  assign marOut = mar_q;
  assign mdrOut = mdr_q;
  assign ready  = ready_q;
  assign accErr = acc_err_q;

endmodule
`default_nettype wire
